// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer between hazard detection and the pipeline latches.
// Optional performance counters are built when STALL_COUNTERS_EN is defined.
module pipeline_stall_controller #(
    parameter int FLUSH_STAGES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             freeze,
    input  logic             flush_req,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    localparam logic FL_IDEX  = (FLUSH_STAGES >= 2);
    localparam logic FL_EXMEM = (FLUSH_STAGES >= 3);

    logic state, state_nxt;
    logic pending_flush, pending_nxt;
    logic mem_stall;
    logic run;

    assign mem_stall = dmem_req & ~dhit;
    // nRST gates the outputs directly so they drop the moment reset asserts.
    assign run       = nRST & (state == ST_RUN);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = nRST & (state == ST_HALTED);
        state_nxt   = state;
        pending_nxt = pending_flush;
        if (run) begin
            if (mem_stall) begin
                if (flush_req) pending_nxt = 1'b1;
            end else if (halt_wb) begin
                state_nxt   = ST_HALTED;
                pending_nxt = 1'b0;
            end else if (flush_req | pending_flush) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = FL_IDEX;
                exmem_flush = FL_EXMEM;
                pending_nxt = 1'b0;
            end else if (freeze) begin
                idex_en     = 1'b1;
                idex_flush  = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else if (!ihit) begin
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= ST_RUN;
            pending_flush <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending_flush <= pending_nxt;
        end
    end

`ifdef STALL_COUNTERS_EN
    logic stall_evt, flush_evt;

    assign stall_evt = run & ~pc_en;
    assign flush_evt = run & ~mem_stall & ~halt_wb & (flush_req | pending_flush);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_evt) stall_cycles <= stall_cycles + 1'b1;
            if (flush_evt) flush_count  <= flush_count + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller; a second instance uses FLUSH_STAGES=1.
module tb_pipeline_stall_controller;
    localparam int CW = 3;

    logic CLK = 1'b0;
    logic nRST, freeze, flush_req, ihit, dmem_req, dhit, halt_wb;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halted;
    logic pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_flush1, idex_flush1, exmem_flush1, halted1;
    logic [CW-1:0] stall_cycles, flush_count, stall_cycles1, flush_count1;
    logic [8:0] outs, outs1;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pipeline_stall_controller #(.FLUSH_STAGES(3), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush_req(flush_req), .ihit(ihit),
        .dmem_req(dmem_req), .dhit(dhit), .halt_wb(halt_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_stall_controller #(.FLUSH_STAGES(1), .CNT_W(CW)) dut1 (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush_req(flush_req), .ihit(ihit),
        .dmem_req(dmem_req), .dhit(dhit), .halt_wb(halt_wb),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .idex_en(idex_en1), .exmem_en(exmem_en1), .memwb_en(memwb_en1),
        .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .exmem_flush(exmem_flush1), .halted(halted1),
        .stall_cycles(stall_cycles1), .flush_count(flush_count1)
    );

    // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes, halted}
    assign outs  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halted};
    assign outs1 = {pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_flush1, idex_flush1, exmem_flush1, halted1};

    localparam logic [8:0] O_ZERO  = 9'b00000_000_0;
    localparam logic [8:0] O_RUN   = 9'b11111_000_0;
    localparam logic [8:0] O_FRZ   = 9'b00111_010_0;
    localparam logic [8:0] O_MISS  = 9'b01111_100_0;
    localparam logic [8:0] O_FL3   = 9'b11111_111_0;
    localparam logic [8:0] O_FL1   = 9'b11111_100_0;
    localparam logic [8:0] O_HALT  = 9'b00000_000_1;

    task automatic drive(input logic fr, input logic fl, input logic ih,
                         input logic dr, input logic dh, input logic hw);
        freeze = fr; flush_req = fl; ihit = ih; dmem_req = dr; dhit = dh; halt_wb = hw;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        drive(0, 0, 1, 0, 0, 0);
        next_cycle();
        next_cycle();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1, 1, 1, 1, 0, 1);
        checks++;
        if (outs !== O_ZERO) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_ZERO); end
        checks++;
        if (stall_cycles !== 0 || flush_count !== 0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        next_cycle();
        next_cycle();
        nRST = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL release_run got=%b exp=%b", outs, O_RUN); end
        next_cycle();
    endtask

    task automatic test_freeze();
        drive(1, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_FRZ) begin failures++; $display("FAIL freeze got=%b exp=%b", outs, O_FRZ); end
        next_cycle();
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL freeze_after got=%b exp=%b", outs, O_RUN); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== O_MISS) begin failures++; $display("FAIL ihit_miss got=%b exp=%b", outs, O_MISS); end
        next_cycle();
    endtask

    task automatic test_flush_priority();
        drive(1, 1, 0, 0, 0, 0);
        checks++;
        if (outs !== O_FL3) begin failures++; $display("FAIL flush_fs3 got=%b exp=%b", outs, O_FL3); end
        checks++;
        if (outs1 !== O_FL1) begin failures++; $display("FAIL flush_fs1 got=%b exp=%b", outs1, O_FL1); end
        next_cycle();
        // held flush_req is applied again in the next cycle
        drive(0, 1, 1, 0, 0, 0);
        checks++;
        if (outs !== O_FL3) begin failures++; $display("FAIL flush_held got=%b exp=%b", outs, O_FL3); end
        next_cycle();
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL flush_after got=%b exp=%b", outs, O_RUN); end
        next_cycle();
    endtask

    task automatic test_mem_stall_flush();
        drive(0, 1, 1, 1, 0, 0);
        checks++;
        if (outs !== O_ZERO) begin failures++; $display("FAIL mstall_c1 got=%b exp=%b", outs, O_ZERO); end
        next_cycle();
        for (int i = 2; i <= 3; i++) begin
            drive(1, 0, 0, 1, 0, 0);
            checks++;
            if (outs !== O_ZERO) begin failures++; $display("FAIL mstall_c%0d got=%b exp=%b", i, outs, O_ZERO); end
            next_cycle();
        end
        drive(0, 0, 1, 1, 1, 0);
        checks++;
        if (outs !== O_FL3) begin failures++; $display("FAIL mstall_release got=%b exp=%b", outs, O_FL3); end
        checks++;
        if (outs1 !== O_FL1) begin failures++; $display("FAIL mstall_release_fs1 got=%b exp=%b", outs1, O_FL1); end
        next_cycle();
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL mstall_cleared got=%b exp=%b", outs, O_RUN); end
        next_cycle();
    endtask

    task automatic test_reset_pending();
        drive(0, 1, 1, 1, 0, 0);
        next_cycle();
        nRST = 1'b0;
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_ZERO) begin failures++; $display("FAIL rst_mid got=%b exp=%b", outs, O_ZERO); end
        next_cycle();
        nRST = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL rst_no_replay got=%b exp=%b", outs, O_RUN); end
        next_cycle();
    endtask

    task automatic test_counters();
        logic [CW-1:0] exp_s, exp_f;
        do_reset();
        drive(1, 0, 1, 0, 0, 0); next_cycle();
        drive(1, 0, 1, 0, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 0, 0); next_cycle();
        drive(0, 1, 1, 0, 0, 0); next_cycle();
        drive(0, 0, 1, 0, 0, 0);
`ifdef STALL_COUNTERS_EN
        exp_s = 3'd3; exp_f = 3'd1;
`else
        exp_s = 3'd0; exp_f = 3'd0;
`endif
        checks++;
        if (stall_cycles !== exp_s) begin failures++; $display("FAIL cnt_stall got=%0d exp=%0d", stall_cycles, exp_s); end
        checks++;
        if (flush_count !== exp_f) begin failures++; $display("FAIL cnt_flush got=%0d exp=%0d", flush_count, exp_f); end
        next_cycle();
        for (int i = 0; i < 5; i++) begin drive(1, 0, 1, 0, 0, 0); next_cycle(); end
        drive(0, 0, 1, 0, 0, 0);
        // 3 + 5 stall cycles wraps the 3-bit counter to 0
        exp_s = 3'd0;
        checks++;
        if (stall_cycles !== exp_s) begin failures++; $display("FAIL cnt_wrap got=%0d exp=%0d", stall_cycles, exp_s); end
        next_cycle();
    endtask

    task automatic test_halt();
        logic [CW-1:0] exp_s, exp_f;
        drive(1, 1, 0, 0, 0, 1);
        checks++;
        if (outs !== O_ZERO) begin failures++; $display("FAIL halt_cycle got=%b exp=%b", outs, O_ZERO); end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 1, i[1], i[1], i[0], ~i[0]);
            checks++;
            if (outs !== O_HALT) begin failures++; $display("FAIL halted_%0d got=%b exp=%b", i, outs, O_HALT); end
            next_cycle();
        end
`ifdef STALL_COUNTERS_EN
        exp_s = 3'd1; exp_f = 3'd1;
`else
        exp_s = 3'd0; exp_f = 3'd0;
`endif
        checks++;
        if (stall_cycles !== exp_s || flush_count !== exp_f) begin
            failures++; $display("FAIL halt_cnt got=%0d/%0d exp=%0d/%0d", stall_cycles, flush_count, exp_s, exp_f);
        end
        nRST = 1'b0;
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_ZERO) begin failures++; $display("FAIL halt_rst got=%b exp=%b", outs, O_ZERO); end
        next_cycle();
        nRST = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        checks++;
        if (outs !== O_RUN) begin failures++; $display("FAIL halt_exit got=%b exp=%b", outs, O_RUN); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_freeze();
        test_flush_priority();
        test_mem_stall_flush();
        test_reset_pending();
        test_counters();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
